// File: rtl/regfile_pkg.sv
// Shared definitions for the register file write arbiter: register file
// geometry, number of write requesters and the arbiter state encoding.
package regfile_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_WR_REQ = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-input round-robin grant. A lone valid requester always wins; on
// contention the registered pointer picks the winner. After a granted
// transfer the pointer moves to the other requester, otherwise it holds.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic ptr_q;
  logic ptr_d;

  // Combinational grant from the valid vector and the priority pointer
  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  // Pointer moves to the requester that did not just transfer
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && (grant_o != 2'b00)) begin
      ptr_d = grant_o[0];
    end
  end

  // Priority pointer register; requester 0 is favoured out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register file write-port arbiter. Two requesters (0: core writeback,
// 1: load/debug) share the single write port through a round-robin grant
// with a valid/ready handshake; the winning write is registered onto the
// register file write port. Writes to x0 complete the handshake but are
// dropped.
// Build option REGFILE_WR_ARB_CLEAR_EN: after reset, write zero into
// x1..x31 on consecutive cycles before accepting any request.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_W,
  parameter int ADDR_WIDTH = REG_ADDR_W
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_WR_REQ-1:0]                  req_valid,
  input  logic [NUM_WR_REQ-1:0][ADDR_WIDTH-1:0]  req_reg,
  input  logic [NUM_WR_REQ-1:0][DATA_WIDTH-1:0]  req_data,
  output logic [NUM_WR_REQ-1:0]                  req_ready,
  output logic                                   rf_wr_en,
  output logic [ADDR_WIDTH-1:0]                  rf_wr_reg,
  output logic [DATA_WIDTH-1:0]                  rf_wr_data,
  output logic                                   clear_done
);

  logic                  run;
  logic                  clr_wr;
  logic [ADDR_WIDTH-1:0] clr_reg;
  logic [NUM_WR_REQ-1:0] grant;
  logic                  xfer;
  logic                  win;

  logic                  rf_wr_en_q,   rf_wr_en_d;
  logic [ADDR_WIDTH-1:0] rf_wr_reg_q,  rf_wr_reg_d;
  logic [DATA_WIDTH-1:0] rf_wr_data_q, rf_wr_data_d;

`ifdef REGFILE_WR_ARB_CLEAR_EN
  arb_state_t            state_q, state_d;
  logic [REG_ADDR_W-1:0] cnt_q,   cnt_d;

  // State and clear counter; the counter starts at 1 so x0 is never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= REG_ADDR_W'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Walk x1..x31; the counter wraps to 0 after x31, which ends the clear
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_wr  = 1'b0;
    case (state_q)
      CLEAR: begin
        if (cnt_q != '0) begin
          clr_wr = 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  assign run        = (state_q == RUN);
  assign clr_reg    = ADDR_WIDTH'(cnt_q);
  assign clear_done = run;
`else
  // Without the clear sequence the arbiter is live whenever reset is low
  assign run        = ~rst;
  assign clr_wr     = 1'b0;
  assign clr_reg    = '0;
  assign clear_done = 1'b1;
`endif

  rr_arbiter_2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (req_valid & {NUM_WR_REQ{run}}),
    .advance_i (xfer),
    .grant_o   (grant)
  );

  // Ready equals grant, so a grant is always a completed transfer
  assign req_ready = grant;
  assign xfer      = |grant;
  assign win       = grant[1];

  // Next write-port contents: clear write, granted write, or idle
  always_comb begin
    rf_wr_en_d   = 1'b0;
    rf_wr_reg_d  = rf_wr_reg_q;
    rf_wr_data_d = rf_wr_data_q;
    if (clr_wr) begin
      rf_wr_en_d   = 1'b1;
      rf_wr_reg_d  = clr_reg;
      rf_wr_data_d = '0;
    end else if (xfer) begin
      rf_wr_en_d   = (req_reg[win] != '0);
      rf_wr_reg_d  = req_reg[win];
      rf_wr_data_d = req_data[win];
    end
  end

  // Registered write port; reset discards any pending write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wr_en_q   <= 1'b0;
      rf_wr_reg_q  <= '0;
      rf_wr_data_q <= '0;
    end else begin
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_reg_q  <= rf_wr_reg_d;
      rf_wr_data_q <= rf_wr_data_d;
    end
  end

  assign rf_wr_en   = rf_wr_en_q;
  assign rf_wr_reg  = rf_wr_reg_q;
  assign rf_wr_data = rf_wr_data_q;

endmodule
